// File: rtl/cosim_dpi_pkg.sv
// Cosimulation endpoint calls (register / tryget) as plain SystemVerilog, so
// the receiver can be exercised without a foreign-language RPC server.
package Cosim_DpiPkg;

  localparam int MAX_MSG_BYTES = 64;

  typedef struct {
    string       ep;
    int unsigned size;
    logic [7:0]  data [MAX_MSG_BYTES];
  } cosim_msg_t;

  string       reg_names[$];
  cosim_msg_t  msg_q[$];
  int unsigned tryget_calls = 0;

  // Nonzero return means the endpoint name is already taken.
  function automatic int cosim_ep_register(input string ep_id,
                                           input longint unsigned send_type_id,
                                           input int send_type_size,
                                           input longint unsigned recv_type_id,
                                           input int recv_type_size);
    foreach (reg_names[i])
      if (reg_names[i] == ep_id) return -1;
    reg_names.push_back(ep_id);
    return 0;
  endfunction

  function automatic int cosim_ep_reg_count();
    return reg_names.size();
  endfunction

  // size_bytes: buffer capacity on entry, true message size on return (0 = none).
  function automatic int cosim_ep_tryget(input string ep_id,
                                         output logic [7:0] buffer [MAX_MSG_BYTES],
                                         inout int unsigned size_bytes);
    bit known;
    known = 1'b0;
    tryget_calls++;
    for (int i = 0; i < MAX_MSG_BYTES; i++) buffer[i] = 8'h00;
    foreach (reg_names[i])
      if (reg_names[i] == ep_id) known = 1'b1;
    if (!known) return -1;
    foreach (msg_q[i]) begin
      if (msg_q[i].ep == ep_id) begin
        for (int b = 0; b < MAX_MSG_BYTES; b++)
          if (b < int'(msg_q[i].size) && b < int'(size_bytes)) buffer[b] = msg_q[i].data[b];
        size_bytes = msg_q[i].size;
        msg_q.delete(i);
        return 0;
      end
    end
    size_bytes = 0;
    return 0;
  endfunction

  // Queue a message of up to 8 bytes; payload byte i is message byte i.
  function automatic void cosim_ep_push(input string ep_id, input int unsigned size,
                                        input logic [63:0] payload);
    cosim_msg_t m;
    m.ep   = ep_id;
    m.size = size;
    for (int i = 0; i < MAX_MSG_BYTES; i++) m.data[i] = 8'h00;
    for (int i = 0; i < 8; i++) m.data[i] = payload[8*i +: 8];
    msg_q.push_back(m);
  endfunction

endpackage

// File: rtl/cosim_ep_recv_pkg.sv
// Shared types for the cosim receive endpoint: FSM state and byte sizing.
package Cosim_EpPkg;
  import Cosim_DpiPkg::*;

  typedef enum logic [2:0] {
    ST_REGISTER = 3'd0,
    ST_IDLE     = 3'd1,
    ST_POLL     = 3'd2,
    ST_HOLD     = 3'd3,
    ST_ERROR    = 3'd4
  } ep_state_t;

  function automatic int unsigned cosim_nbytes(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/cosim_ep_recv.sv
// Cosim receive endpoint: polls the host for messages and presents them on a
// valid/ready port. Define COSIM_EP_RECV_PREFETCH_EN for a one-entry prefetch.
module cosim_ep_recv
  import Cosim_DpiPkg::*;
  import Cosim_EpPkg::*;
#(
  parameter string       ENDPOINT_ID         = "",
  parameter logic [63:0] SEND_TYPE_ID        = 64'd0,
  parameter int          SEND_TYPE_SIZE_BITS = 8,
  parameter int          POLL_INTERVAL       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [SEND_TYPE_SIZE_BITS-1:0] DataOut,
  output logic                           DataOutValid,
  input  logic                           DataOutReady,
  output logic                           Error,
  output logic                           SizeMismatch
);

  localparam int          W          = SEND_TYPE_SIZE_BITS;
  localparam int unsigned NBYTES     = cosim_nbytes(SEND_TYPE_SIZE_BITS);
  localparam logic [31:0] CNT_RELOAD = 32'(POLL_INTERVAL);

  // Handshake: a transfer completes on the rising edge where DataOutValid and
  // DataOutReady are both high; DataOut is frozen while valid waits for ready.
  typedef struct packed {
    ep_state_t   state;
    logic        registered;
    logic        valid;
    logic [W-1:0] data;
    logic        error;
    logic        mismatch;
    logic [31:0] cnt;
`ifdef COSIM_EP_RECV_PREFETCH_EN
    logic        pf_valid;
    logic [W-1:0] pf_data;
`endif
  } regs_t;

  typedef struct packed {
    int           rc;
    int unsigned  size;
    logic [W-1:0] data;
  } poll_t;

  // registered survives rst so the host sees exactly one registration.
  regs_t r = '0;

  function automatic poll_t poll_once();
    poll_t               p;
    logic [7:0]          buffer [MAX_MSG_BYTES];
    int unsigned         sz;
    logic [8*NBYTES-1:0] wide;
    sz     = NBYTES;
    p.rc   = cosim_ep_tryget(ENDPOINT_ID, buffer, sz);
    p.size = sz;
    wide   = '0;
    for (int i = 0; i < int'(NBYTES); i++) wide[8*i +: 8] = buffer[i];
    p.data = wide[W-1:0];
    return p;
  endfunction

  function automatic regs_t step(input regs_t cur, input logic ready, input logic reset);
    regs_t nx;
    poll_t p;
    nx          = cur;
    nx.mismatch = 1'b0;
    if (reset) begin
      nx.state = cur.registered ? ST_IDLE : ST_REGISTER;
      nx.valid = 1'b0;
      nx.data  = '0;
      nx.error = 1'b0;
      nx.cnt   = CNT_RELOAD;
`ifdef COSIM_EP_RECV_PREFETCH_EN
      nx.pf_valid = 1'b0;
      nx.pf_data  = '0;
`endif
      return nx;
    end
    case (cur.state)
      ST_REGISTER: begin
        nx.registered = 1'b1;
        if (cosim_ep_register(ENDPOINT_ID, SEND_TYPE_ID, int'(NBYTES), 64'd0, 0) == 0)
          nx.state = ST_IDLE;
        else begin
          nx.state = ST_ERROR;
          nx.error = 1'b1;
        end
      end
      ST_IDLE: begin
        if (cur.cnt <= 32'd1) nx.state = ST_POLL;
        else                  nx.cnt   = cur.cnt - 32'd1;
      end
      ST_POLL: begin
        p      = poll_once();
        nx.cnt = CNT_RELOAD;
        if (p.rc < 0) begin
          nx.state = ST_ERROR;
          nx.error = 1'b1;
        end else if (p.size == 0) begin
          nx.state = ST_IDLE;
        end else if (p.size != NBYTES) begin
          nx.mismatch = 1'b1;
          nx.state    = ST_IDLE;
        end else begin
          nx.data  = p.data;
          nx.valid = 1'b1;
          nx.state = ST_HOLD;
        end
      end
      ST_HOLD: begin
`ifdef COSIM_EP_RECV_PREFETCH_EN
        logic got;
        got = 1'b0;
        p   = '0;
        if (!cur.pf_valid) begin
          if (cur.cnt <= 32'd1) begin
            p      = poll_once();
            nx.cnt = CNT_RELOAD;
            if (p.rc < 0) begin
              nx.state    = ST_ERROR;
              nx.error    = 1'b1;
              nx.valid    = 1'b0;
              nx.pf_valid = 1'b0;
              return nx;
            end else if (p.size == NBYTES) got = 1'b1;
            else if (p.size != 0)          nx.mismatch = 1'b1;
          end else begin
            nx.cnt = cur.cnt - 32'd1;
          end
        end
        if (ready) begin
          if (cur.pf_valid) begin
            nx.data     = cur.pf_data;
            nx.pf_valid = 1'b0;
          end else if (got) begin
            nx.data = p.data;
          end else begin
            nx.valid = 1'b0;
            nx.state = ST_IDLE;
            nx.cnt   = CNT_RELOAD;
          end
        end else if (got) begin
          nx.pf_data  = p.data;
          nx.pf_valid = 1'b1;
        end
`else
        if (ready) begin
          nx.valid = 1'b0;
          nx.state = ST_IDLE;
          nx.cnt   = CNT_RELOAD;
        end
`endif
      end
      ST_ERROR: begin
        nx.error = 1'b1;
        nx.valid = 1'b0;
      end
      default: begin
        nx.state = ST_ERROR;
        nx.error = 1'b1;
        nx.valid = 1'b0;
      end
    endcase
    return nx;
  endfunction

  always_ff @(posedge clk) begin
    r <= step(r, DataOutReady, rst);
  end

  assign DataOut      = r.data;
  assign DataOutValid = r.valid;
  assign Error        = r.error;
  assign SizeMismatch = r.mismatch;

endmodule

// File: tb/tb_cosim_ep_recv.sv
// Directed bench for cosim_ep_recv: vector table plus hand-written sequences
// for back-pressure, duplicate registration, mid-transfer reset and prefetch.
module tb_cosim_ep_recv;
  import Cosim_DpiPkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rst_dup = 1'b1;
  logic         ready = 1'b0;
  logic         dup_ready = 1'b1;
  logic [W-1:0] data_out;
  logic [W-1:0] dup_data;
  logic         valid, error, size_mismatch;
  logic         dup_valid, dup_error, dup_mismatch;

  int n_checks = 0;
  int n_pass   = 0;
  int dup_valid_cycles = 0;

  always #5 clk = ~clk;

  cosim_ep_recv #(
    .ENDPOINT_ID("ep_main"), .SEND_TYPE_ID(64'h0000_0000_0000_1234),
    .SEND_TYPE_SIZE_BITS(W), .POLL_INTERVAL(1)
  ) dut (
    .clk(clk), .rst(rst), .DataOut(data_out), .DataOutValid(valid),
    .DataOutReady(ready), .Error(error), .SizeMismatch(size_mismatch)
  );

  cosim_ep_recv #(
    .ENDPOINT_ID("ep_dup"), .SEND_TYPE_ID(64'h0000_0000_0000_5678),
    .SEND_TYPE_SIZE_BITS(W), .POLL_INTERVAL(1)
  ) dut_dup (
    .clk(clk), .rst(rst_dup), .DataOut(dup_data), .DataOutValid(dup_valid),
    .DataOutReady(dup_ready), .Error(dup_error), .SizeMismatch(dup_mismatch)
  );

  always @(negedge clk) if (dup_valid) dup_valid_cycles++;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic wait_valid(input int budget, output bit seen, output int mm_cycles,
                            output int unsigned call_delta);
    int unsigned prev;
    seen = 1'b0;
    mm_cycles = 0;
    call_delta = 0;
    prev = tryget_calls;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (size_mismatch) mm_cycles++;
      if (valid) begin
        seen = 1'b1;
        call_delta = tryget_calls - prev;
      end else prev = tryget_calls;
    end
  endtask

  task automatic observe(input int cycles, output int v_cycles, output int mm_cycles);
    v_cycles = 0;
    mm_cycles = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid) v_cycles++;
      if (size_mismatch) mm_cycles++;
    end
  endtask

  task automatic accept();
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0]  payload;
    int unsigned  nbytes;
    logic [W-1:0] exp_data;
    bit           exp_drop;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit           seen;
    int           mm, vc;
    int unsigned  delta, calls_mark;
    logic [W-1:0] held;
    logic [W-1:0] got_data[$];
    int           got_cyc[$];

    vecs[0] = '{64'h0000_0000_1234_5678, 4, 32'h1234_5678, 1'b0};
    vecs[1] = '{64'h0000_0000_DEAD_BEEF, 4, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{64'h0000_0000_00AB_CDEF, 3, 32'h0,         1'b1};
    vecs[3] = '{64'h0000_0000_0000_0001, 4, 32'h0000_0001, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_00A5, 1, 32'h0,         1'b1};
    vecs[5] = '{64'h0000_0088_99AA_BBCC, 5, 32'h0,         1'b1};
    vecs[6] = '{64'h0000_0000_FFFF_FFFF, 4, 32'hFFFF_FFFF, 1'b0};

    // The duplicate endpoint's name is claimed before its instance registers.
    void'(cosim_ep_register("ep_dup", 64'd0, 4, 64'd0, 0));

    repeat (3) @(negedge clk);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_data", 64'(data_out), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    check("reset_mismatch", 64'(size_mismatch), 64'd0);
    check("reset_dup_error", 64'(dup_error), 64'd0);

    rst = 1'b0;
    rst_dup = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk);
      if (dup_error) seen = 1'b1;
    end
    check("dup_error_within_2", 64'(seen), 64'd1);

    for (int v = 0; v < 7; v++) begin
      cosim_ep_push("ep_main", vecs[v].nbytes, vecs[v].payload);
      if (vecs[v].exp_drop) begin
        observe(8, vc, mm);
        check($sformatf("vec%0d_mismatch_pulse", v), 64'(mm), 64'd1);
        check($sformatf("vec%0d_no_valid", v), 64'(vc), 64'd0);
      end else begin
        wait_valid(20, seen, mm, delta);
        check($sformatf("vec%0d_valid_seen", v), 64'(seen), 64'd1);
        check($sformatf("vec%0d_data", v), 64'(data_out), 64'(vecs[v].exp_data));
        check($sformatf("vec%0d_poll_latency", v), 64'(delta), 64'd1);
        check($sformatf("vec%0d_no_mismatch", v), 64'(mm), 64'd0);
        accept();
      end
    end

    // Back-pressure: ten cycles with ready low.
    cosim_ep_push("ep_main", 4, 64'h0000_0000_CAFE_F00D);
    wait_valid(20, seen, mm, delta);
    check("bp_valid_seen", 64'(seen), 64'd1);
    held = data_out;
    check("bp_first_data", 64'(held), 64'h0000_0000_CAFE_F00D);
    calls_mark = tryget_calls;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", i), 64'(valid), 64'd1);
      check($sformatf("bp_data_c%0d", i), 64'(data_out), 64'h0000_0000_CAFE_F00D);
    end
`ifndef COSIM_EP_RECV_PREFETCH_EN
    check("bp_no_tryget_in_hold", 64'(tryget_calls - calls_mark), 64'd0);
`endif
    accept();
    @(negedge clk);
    check("bp_valid_after_xfer", 64'(valid), 64'd0);

    // Reset while holding a message: discarded, no replay, no re-registration.
    cosim_ep_push("ep_main", 4, 64'h0000_0000_600D_F00D);
    wait_valid(20, seen, mm, delta);
    check("hold_rst_valid_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_rst_valid_low", 64'(valid), 64'd0);
    check("hold_rst_data_zero", 64'(data_out), 64'd0);
    rst = 1'b0;
    observe(6, vc, mm);
    check("hold_rst_no_replay", 64'(vc), 64'd0);
    check("hold_rst_reg_count", 64'(cosim_ep_reg_count()), 64'd2);
    check("hold_rst_no_error", 64'(error), 64'd0);
    cosim_ep_push("ep_main", 4, 64'h0000_0000_0BAD_C0DE);
    wait_valid(20, seen, mm, delta);
    check("after_rst_valid_seen", 64'(seen), 64'd1);
    check("after_rst_data", 64'(data_out), 64'h0000_0000_0BAD_C0DE);
    accept();

`ifdef COSIM_EP_RECV_PREFETCH_EN
    // Two queued messages with ready tied high stream on consecutive cycles.
    @(negedge clk);
    ready = 1'b1;
    cosim_ep_push("ep_main", 4, 64'h0000_0000_1111_2222);
    cosim_ep_push("ep_main", 4, 64'h0000_0000_3333_4444);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) begin
        got_data.push_back(data_out);
        got_cyc.push_back(i);
      end
    end
    ready = 1'b0;
    check("pf_count", 64'(got_data.size()), 64'd2);
    if (got_data.size() >= 2) begin
      check("pf_first", 64'(got_data[0]), 64'h0000_0000_1111_2222);
      check("pf_second", 64'(got_data[1]), 64'h0000_0000_3333_4444);
      check("pf_back_to_back", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
    end
`endif

    repeat (2) @(negedge clk);
    check("dup_never_valid", 64'(dup_valid_cycles), 64'd0);
    check("dup_error_sticky", 64'(dup_error), 64'd1);
    check("main_error_clear", 64'(error), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
